regfile_bypass: RTL and testbench

Parametrised successor to the team's 4x4 register file. It adds a synchronous clear sequence with a `busy` flag and an optional hard-wired zero register, and reports each write as accepted or rejected. It also forwards write data to both read ports in the same cycle. It sits between the datapath controller and the ALU operand muxes, with two combinational read ports and one synchronous write port.

---
 rtl/regfile_bypass.sv | 107 ++++++++++
 tb/tb_regfile_bypass.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with a power-up clear sequence, optional hard-wired zero register,
// same-cycle write-to-read forwarding and registered accept/reject pulses for each write request.
module regfile_bypass #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int REG_COUNT  = 8,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  busy,
    output logic                  wr_ack,
    output logic                  wr_err
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // One extra bit so REG_COUNT == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   COUNT_EXT = (ADDR_WIDTH + 1)'(REG_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(REG_COUNT - 1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  wr_accept;
    logic                  wr_reject;

    function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < COUNT_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // A request arriving while rst is high is dropped, even if the FSM is still in READY.
    assign wr_accept = !rst && (state == READY) && wr_en && addr_valid(wr_addr);
    assign wr_reject = !rst && (state == READY) && wr_en && !addr_valid(wr_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (cnt == LAST_IDX) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_accept;
            wr_err <= wr_reject;
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else if (wr_accept) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data1 = '0;
        if ((state == READY) && addr_valid(rd_addr1)) begin
            rd_data1 = (wr_accept && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
        end
    end

    always_comb begin
        rd_data2 = '0;
        if ((state == READY) && addr_valid(rd_addr2)) begin
            rd_data2 = (wr_accept && (wr_addr == rd_addr2)) ? wr_data : regs[rd_addr2];
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: instance a uses defaults (8 regs, zero register),
// instance b uses 6 registers with register 0 ordinary, for the out-of-range cases.
module tb_regfile_bypass;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr1;
    logic [2:0] rd_addr2;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic       busy;
    logic       wr_ack;
    logic       wr_err;

    logic       b_wr_en;
    logic [2:0] b_wr_addr;
    logic [7:0] b_wr_data;
    logic [2:0] b_rd_addr1;
    logic [2:0] b_rd_addr2;
    logic [7:0] b_rd_data1;
    logic [7:0] b_rd_data2;
    logic       b_busy;
    logic       b_wr_ack;
    logic       b_wr_err;

    int tests;
    int fails;

    regfile_bypass #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .REG_COUNT(8), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy(busy), .wr_ack(wr_ack), .wr_err(wr_err)
    );

    regfile_bypass #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .REG_COUNT(6), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2), .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
        .busy(b_busy), .wr_ack(b_wr_ack), .wr_err(b_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        #1;
        tests += 3;
        if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
        if (wr_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", wr_err); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            rd_addr2 = 3'(7 - i);
            #1;
            tests += 5;
            if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy[%0d]: got %b want 1", i, busy); end
            if (rd_data1 !== 8'h00) begin fails++; $display("FAIL clear_rd1[%0d]: got %h want 00", i, rd_data1); end
            if (rd_data2 !== 8'h00) begin fails++; $display("FAIL clear_rd2[%0d]: got %h want 00", i, rd_data2); end
            if (wr_ack !== 1'b0) begin fails++; $display("FAIL clear_ack[%0d]: got %b want 0", i, wr_ack); end
            if (wr_err !== 1'b0) begin fails++; $display("FAIL clear_err[%0d]: got %b want 0", i, wr_err); end
            step();
        end
        #1;
        tests += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL clear_done_busy: got %b want 0", busy); end
        if (b_busy !== 1'b0) begin fails++; $display("FAIL clear_done_b_busy: got %b want 0", b_busy); end
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i);
            rd_addr2 = 3'(i);
            #1;
            tests += 2;
            if (rd_data1 !== 8'h00) begin fails++; $display("FAIL post_clear_rd1[%0d]: got %h want 00", i, rd_data1); end
            if (rd_data2 !== 8'h00) begin fails++; $display("FAIL post_clear_rd2[%0d]: got %h want 00", i, rd_data2); end
        end
        tests += 2;
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL post_clear_ack: got %b want 0", wr_ack); end
        if (wr_err !== 1'b0) begin fails++; $display("FAIL post_clear_err: got %b want 0", wr_err); end
    endtask

    task automatic test_basic_write();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        rd_addr1 = 3'd3; rd_addr2 = 3'd4;
        step();
        wr_en = 1'b0;
        #1;
        tests += 4;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL basic_ack: got %b want 1", wr_ack); end
        if (wr_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", wr_err); end
        if (rd_data1 !== 8'hA5) begin fails++; $display("FAIL basic_rd1: got %h want a5", rd_data1); end
        if (rd_data2 !== 8'h00) begin fails++; $display("FAIL basic_rd2: got %h want 00", rd_data2); end
        step();
        #1;
        tests += 3;
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL basic_ack_pulse: got %b want 0", wr_ack); end
        if (rd_data1 !== 8'hA5) begin fails++; $display("FAIL basic_rd1_hold: got %h want a5", rd_data1); end
        if (rd_data2 !== 8'h00) begin fails++; $display("FAIL basic_rd2_hold: got %h want 00", rd_data2); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        rd_addr1 = 3'd5; rd_addr2 = 3'd5;
        #1;
        tests += 2;
        if (rd_data1 !== 8'h3C) begin fails++; $display("FAIL bypass_rd1: got %h want 3c", rd_data1); end
        if (rd_data2 !== 8'h3C) begin fails++; $display("FAIL bypass_rd2: got %h want 3c", rd_data2); end
        step();
        wr_en = 1'b0;
        #1;
        tests += 3;
        if (rd_data1 !== 8'h3C) begin fails++; $display("FAIL bypass_rd1_after: got %h want 3c", rd_data1); end
        if (rd_data2 !== 8'h3C) begin fails++; $display("FAIL bypass_rd2_after: got %h want 3c", rd_data2); end
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL bypass_ack: got %b want 1", wr_ack); end
        // Overwrite with a new value: forwarding must win over the stored 0x3C.
        wr_en = 1'b1; wr_data = 8'hC3;
        #1;
        tests += 1;
        if (rd_data1 !== 8'hC3) begin fails++; $display("FAIL bypass_overwrite: got %h want c3", rd_data1); end
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] addrs [3];
        logic [7:0] datas [3];
        addrs[0] = 3'd1; addrs[1] = 3'd2; addrs[2] = 3'd6;
        datas[0] = 8'h12; datas[1] = 8'h34; datas[2] = 8'h56;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = addrs[i]; wr_data = datas[i];
            step();
            #1;
            tests += 2;
            if (wr_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, wr_ack); end
            if (wr_err !== 1'b0) begin fails++; $display("FAIL b2b_err[%0d]: got %b want 0", i, wr_err); end
        end
        // Reject followed immediately by accept: flags must alternate, never both high.
        wr_addr = 3'd0; wr_data = 8'hEE;
        step();
        wr_addr = 3'd7; wr_data = 8'h78;
        #1;
        tests += 2;
        if (wr_err !== 1'b1) begin fails++; $display("FAIL b2b_rej_err: got %b want 1", wr_err); end
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL b2b_rej_ack: got %b want 0", wr_ack); end
        step();
        wr_en = 1'b0;
        #1;
        tests += 2;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL b2b_acc_ack: got %b want 1", wr_ack); end
        if (wr_err !== 1'b0) begin fails++; $display("FAIL b2b_acc_err: got %b want 0", wr_err); end
        for (int i = 0; i < 3; i++) begin
            rd_addr1 = addrs[i]; rd_addr2 = addrs[2 - i];
            #1;
            tests += 2;
            if (rd_data1 !== datas[i]) begin fails++; $display("FAIL b2b_rd1[%0d]: got %h want %h", i, rd_data1, datas[i]); end
            if (rd_data2 !== datas[2 - i]) begin fails++; $display("FAIL b2b_rd2[%0d]: got %h want %h", i, rd_data2, datas[2 - i]); end
        end
        rd_addr1 = 3'd7; rd_addr2 = 3'd3;
        #1;
        tests += 2;
        if (rd_data1 !== 8'h78) begin fails++; $display("FAIL b2b_rd7: got %h want 78", rd_data1); end
        if (rd_data2 !== 8'hA5) begin fails++; $display("FAIL b2b_rd3: got %h want a5", rd_data2); end
    endtask

    task automatic test_rejected();
        logic [7:0] exp_b [6];
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        rd_addr1 = 3'd0;
        #1;
        tests += 1;
        if (rd_data1 !== 8'h00) begin fails++; $display("FAIL zero_bypass: got %h want 00", rd_data1); end
        step();
        wr_en = 1'b0;
        #1;
        tests += 3;
        if (wr_err !== 1'b1) begin fails++; $display("FAIL zero_err: got %b want 1", wr_err); end
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL zero_ack: got %b want 0", wr_ack); end
        if (rd_data1 !== 8'h00) begin fails++; $display("FAIL zero_rd: got %h want 00", rd_data1); end
        // Instance b: register 0 is ordinary, registers 6 and 7 do not exist.
        b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 8'h99; b_rd_addr1 = 3'd0;
        #1;
        tests += 1;
        if (b_rd_data1 !== 8'h99) begin fails++; $display("FAIL b_reg0_bypass: got %h want 99", b_rd_data1); end
        step();
        b_wr_addr = 3'd5; b_wr_data = 8'h66;
        #1;
        tests += 1;
        if (b_wr_ack !== 1'b1) begin fails++; $display("FAIL b_reg0_ack: got %b want 1", b_wr_ack); end
        step();
        b_wr_addr = 3'd7; b_wr_data = 8'hEE; b_rd_addr1 = 3'd7; b_rd_addr2 = 3'd5;
        #1;
        tests += 2;
        if (b_rd_data1 !== 8'h00) begin fails++; $display("FAIL b_oor_bypass: got %h want 00", b_rd_data1); end
        if (b_rd_data2 !== 8'h66) begin fails++; $display("FAIL b_reg5_rd: got %h want 66", b_rd_data2); end
        step();
        b_wr_en = 1'b0;
        #1;
        tests += 3;
        if (b_wr_err !== 1'b1) begin fails++; $display("FAIL b_oor_err: got %b want 1", b_wr_err); end
        if (b_wr_ack !== 1'b0) begin fails++; $display("FAIL b_oor_ack: got %b want 0", b_wr_ack); end
        if (b_rd_data1 !== 8'h00) begin fails++; $display("FAIL b_oor_rd7: got %h want 00", b_rd_data1); end
        b_rd_addr1 = 3'd6;
        #1;
        tests += 1;
        if (b_rd_data1 !== 8'h00) begin fails++; $display("FAIL b_oor_rd6: got %h want 00", b_rd_data1); end
        exp_b[0] = 8'h99; exp_b[1] = 8'h00; exp_b[2] = 8'h00;
        exp_b[3] = 8'h00; exp_b[4] = 8'h00; exp_b[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            b_rd_addr2 = 3'(i);
            #1;
            tests += 1;
            if (b_rd_data2 !== exp_b[i]) begin fails++; $display("FAIL b_regs[%0d]: got %h want %h", i, b_rd_data2, exp_b[i]); end
        end
    endtask

    task automatic test_write_during_busy();
        // rst while READY: contents still readable in that cycle, and the concurrent write is dropped.
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h44; rd_addr1 = 3'd3;
        #1;
        tests += 1;
        if (rd_data1 !== 8'hA5) begin fails++; $display("FAIL rst_ready_rd: got %h want a5", rd_data1); end
        step();
        rst = 1'b0; wr_addr = 3'd2; wr_data = 8'h11;
        for (int i = 0; i < 8; i++) begin
            wr_en = (i == 4);
            #1;
            tests += 4;
            if (busy !== 1'b1) begin fails++; $display("FAIL wbusy_busy[%0d]: got %b want 1", i, busy); end
            if (wr_ack !== 1'b0) begin fails++; $display("FAIL wbusy_ack[%0d]: got %b want 0", i, wr_ack); end
            if (wr_err !== 1'b0) begin fails++; $display("FAIL wbusy_err[%0d]: got %b want 0", i, wr_err); end
            if (rd_data1 !== 8'h00) begin fails++; $display("FAIL wbusy_rd[%0d]: got %h want 00", i, rd_data1); end
            step();
        end
        wr_en = 1'b0; rd_addr1 = 3'd2; rd_addr2 = 3'd3;
        #1;
        tests += 5;
        if (busy !== 1'b0) begin fails++; $display("FAIL wbusy_done: got %b want 0", busy); end
        if (wr_ack !== 1'b0) begin fails++; $display("FAIL wbusy_last_ack: got %b want 0", wr_ack); end
        if (wr_err !== 1'b0) begin fails++; $display("FAIL wbusy_last_err: got %b want 0", wr_err); end
        if (rd_data1 !== 8'h00) begin fails++; $display("FAIL wbusy_reg2: got %h want 00", rd_data1); end
        if (rd_data2 !== 8'h00) begin fails++; $display("FAIL wbusy_reg3: got %h want 00", rd_data2); end
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests += 1;
            if (busy !== 1'b1) begin fails++; $display("FAIL mid_pre_busy[%0d]: got %b want 1", i, busy); end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests += 1;
            if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy[%0d]: got %b want 1", i, busy); end
            step();
        end
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h77; rd_addr1 = 3'd6;
        #1;
        tests += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_done: got %b want 0", busy); end
        if (rd_data1 !== 8'h77) begin fails++; $display("FAIL mid_bypass: got %h want 77", rd_data1); end
        step();
        wr_en = 1'b0;
        #1;
        tests += 3;
        if (wr_ack !== 1'b1) begin fails++; $display("FAIL mid_ack: got %b want 1", wr_ack); end
        if (wr_err !== 1'b0) begin fails++; $display("FAIL mid_err: got %b want 0", wr_err); end
        if (rd_data1 !== 8'h77) begin fails++; $display("FAIL mid_rd: got %h want 77", rd_data1); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr1 = '0; b_rd_addr2 = '0;
        test_reset();
        test_basic_write();
        test_bypass();
        test_back_to_back();
        test_rejected();
        test_write_during_busy();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
